// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART receiver and its echo transmitter.
package uart_pkg;

    localparam int   UART_CLKS_PER_BIT = 20;
    localparam int   DATA_BITS         = 8;
    localparam int   FRAME_BITS        = 11;
    localparam logic IDLE_LEVEL        = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_e;

endpackage

// File: rtl/uart_receive_if.sv
// Serial link and byte-side signals of the UART receiver, grouped for the host and the receiver.
interface uart_receive_if;
    import uart_pkg::*;

    logic                 rx_i;
    logic [DATA_BITS-1:0] data;
    logic                 ready;
    logic                 reset_ready;
    logic                 tx_o;

    modport master (output rx_i, output reset_ready, input data, input ready, input tx_o);
    modport slave  (input rx_i, input reset_ready, output data, output ready, output tx_o);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: sends {start, data[0..7], data[8], stop}, each bit CLKS_PER_BIT cycles long.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [DATA_BITS:0] data,
    input  logic           send,
    output logic           busy,
    output logic           tx_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    tx_state_e             state_q;
    logic [CW-1:0]         cnt_q;
    logic [3:0]            bit_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  tx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            tx_q    <= IDLE_LEVEL;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (send) begin
                        shift_q <= {IDLE_LEVEL, data, 1'b0};
                        tx_q    <= 1'b0;
                        cnt_q   <= CW'(CLKS_PER_BIT - 1);
                        bit_q   <= '0;
                        state_q <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (cnt_q == '0) begin
                        if (bit_q == 4'(FRAME_BITS - 1)) begin
                            tx_q    <= IDLE_LEVEL;
                            state_q <= TX_IDLE;
                        end else begin
                            // shift_q[0] is the bit currently on the line
                            tx_q    <= shift_q[1];
                            shift_q <= {IDLE_LEVEL, shift_q[FRAME_BITS-1:1]};
                            bit_q   <= bit_q + 4'd1;
                            cnt_q   <= CW'(CLKS_PER_BIT - 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign busy = (state_q == TX_SHIFT);
    assign tx_o = tx_q;
endmodule

// File: rtl/uart_receive.sv
// UART receiver (8E1) with sticky ready flag and echo of every good byte through uart_transmitter.
// Define UART_PARITY_CHECK_EN to reject frames whose parity bit is not the even parity of the data.
module uart_receive
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input logic           clk,
    input logic           reset,
    uart_receive_if.slave bus
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    rx_state_e            state_q;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 ready_q;
    logic                 frame_err_q;
    logic                 echo_pend_q;
    logic                 parity_ok;
    logic                 tx_busy;
    logic                 tx_send;

`ifdef UART_PARITY_CHECK_EN
    logic par_q;
    assign parity_ok = (par_q == ^shift_q);
`else
    assign parity_ok = 1'b1;
`endif

    // The transmitter frees exactly one frame after it started, so a pending echo waits for it.
    assign tx_send = echo_pend_q && !tx_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RX_IDLE;
            rx_meta_q   <= IDLE_LEVEL;
            rx_sync_q   <= IDLE_LEVEL;
            rx_prev_q   <= IDLE_LEVEL;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            echo_pend_q <= 1'b0;
`ifdef UART_PARITY_CHECK_EN
            par_q       <= 1'b0;
`endif
        end else begin
            rx_meta_q <= bus.rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            // Later assignments in the FSM override these, so a new byte beats the clear.
            if (bus.reset_ready) ready_q <= 1'b0;
            if (tx_send) echo_pend_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    frame_err_q <= 1'b0;
                    if (rx_prev_q && !rx_sync_q) begin
                        cnt_q   <= CW'(HALF);
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CW'(CLKS_PER_BIT - 1);
                        bit_q   <= '0;
                        state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 3'd1;
                        cnt_q   <= CW'(CLKS_PER_BIT - 1);
                        if (bit_q == 3'd7) state_q <= RX_PARITY;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (cnt_q == '0) begin
`ifdef UART_PARITY_CHECK_EN
                        par_q   <= rx_sync_q;
`endif
                        cnt_q   <= CW'(CLKS_PER_BIT - 1);
                        state_q <= RX_STOP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!rx_sync_q) begin
                        frame_err_q <= 1'b1;
                    end else begin
                        if (!frame_err_q && parity_ok) begin
                            data_q      <= shift_q;
                            ready_q     <= 1'b1;
                            echo_pend_q <= 1'b1;
                        end
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    uart_transmitter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_echo_tx (
        .clk   (clk),
        .reset (reset),
        .data  ({^data_q, data_q}),
        .send  (tx_send),
        .busy  (tx_busy),
        .tx_o  (bus.tx_o)
    );

    assign bus.data  = data_q;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive (echo checked by a scoreboard monitor) and standalone uart_transmitter.
module tb_uart_receive;
    localparam int CPB = 20;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    uart_receive_if bus();

    uart_receive #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [8:0] t_data;
    logic       t_send;
    logic       t_busy;
    logic       t_tx;

    uart_transmitter #(.CLKS_PER_BIT(CPB)) u_tx (
        .clk   (clk),
        .reset (reset),
        .data  (t_data),
        .send  (t_send),
        .busy  (t_busy),
        .tx_o  (t_tx)
    );

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [10:0] echo_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame LSB-first; optionally queue the echo the receiver should send back.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input logic expect_echo);
        logic [10:0] fr;
        fr = {stop, par, b, 1'b0};
        if (expect_echo) echo_q.push_back({1'b1, ^b, b, 1'b0});
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.rx_i = fr[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        bus.rx_i = 1'b1;
    endtask

    // Echo monitor: sample each tx_o bit mid-bit and compare with the oldest queued frame.
    initial begin
        logic [10:0] got;
        logic [10:0] exp;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (bus.tx_o === 1'b0) begin
                repeat (9) @(negedge clk);
                got[0] = bus.tx_o;
                for (int i = 1; i < 11; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = bus.tx_o;
                end
                exp = (echo_q.size() > 0) ? echo_q.pop_front() : 11'h000;
                chk("echo_frame", {21'd0, got}, {21'd0, exp});
                $display("echo frame observed %b expected %b", got, exp);
            end
        end
    end

    initial begin
        int busy_cnt;
        int wait_cnt;
        logic [10:0] tgot;

        reset          = 1'b0;
        bus.rx_i       = 1'b1;
        bus.reset_ready = 1'b0;
        t_data         = '0;
        t_send         = 1'b0;

        // 1: reset and idle
        repeat (5) @(negedge clk);
        chk("reset_tx_o", {31'd0, bus.tx_o}, 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat (5) @(negedge clk);
            chk("idle_tx_o", {31'd0, bus.tx_o}, 32'd1);
        end
        chk("reset_data", {24'd0, bus.data}, 32'd0);
        chk("reset_ready", {31'd0, bus.ready}, 32'd0);
        chk("reset_tx_busy", {31'd0, t_busy}, 32'd0);
        mon_en = 1'b1;

        // 2: single frame 0x1D, even parity 0
        send_frame(8'h1D, 1'b0, 1'b1, 1'b1);
        $display("frame 0x1D: data=%0h ready=%0b", bus.data, bus.ready);
        chk("f1_data", {24'd0, bus.data}, 32'h1D);
        chk("f1_ready", {31'd0, bus.ready}, 32'd1);
        repeat (40) @(negedge clk);

        // 3: back-to-back frames, then clear ready
        send_frame(8'hE2, 1'b0, 1'b1, 1'b1);
        $display("frame 0xE2: data=%0h ready=%0b", bus.data, bus.ready);
        chk("b2b_data0", {24'd0, bus.data}, 32'hE2);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        $display("frame 0xFF: data=%0h ready=%0b", bus.data, bus.ready);
        chk("b2b_data1", {24'd0, bus.data}, 32'hFF);
        chk("b2b_ready", {31'd0, bus.ready}, 32'd1);
        bus.reset_ready = 1'b1;
        @(negedge clk);
        bus.reset_ready = 1'b0;
        @(negedge clk);
        chk("ready_cleared", {31'd0, bus.ready}, 32'd0);

        // 4: standalone transmitter, second send while busy must be ignored
        t_data = 9'b1_0101_0111;
        t_send = 1'b1;
        @(negedge clk);
        t_send   = 1'b0;
        busy_cnt = 0;
        tgot     = '0;
        for (int k = 0; k < 260; k++) begin
            if (k > 0) @(negedge clk);
            if (t_busy) busy_cnt++;
            if ((k % CPB) == 10 && (k / CPB) < 11) tgot[k / CPB] = t_tx;
            if (k == 50) begin
                t_data = 9'h000;
                t_send = 1'b1;
            end
            if (k == 51) t_send = 1'b0;
        end
        $display("standalone tx: bits=%b busy_cycles=%0d", tgot, busy_cnt);
        chk("tx_bits", {21'd0, tgot}, 32'b110_1010_1110);
        chk("tx_busy_cycles", busy_cnt, 32'd220);
        chk("tx_idle_after", {30'd0, t_busy, t_tx}, 32'b01);

        // 5: start glitch and framing error
        bus.rx_i = 1'b0;
        repeat (5) @(negedge clk);
        bus.rx_i = 1'b1;
        repeat (300) @(negedge clk);
        $display("glitch: data=%0h ready=%0b", bus.data, bus.ready);
        chk("glitch_ready", {31'd0, bus.ready}, 32'd0);
        chk("glitch_data", {24'd0, bus.data}, 32'hFF);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        $display("framing error: data=%0h ready=%0b", bus.data, bus.ready);
        chk("frm_err_ready", {31'd0, bus.ready}, 32'd0);
        chk("frm_err_data", {24'd0, bus.data}, 32'hFF);

        // 6: wrong parity
`ifdef UART_PARITY_CHECK_EN
        send_frame(8'h1D, 1'b1, 1'b1, 1'b0);
        $display("bad parity (checked): data=%0h ready=%0b", bus.data, bus.ready);
        chk("par_data", {24'd0, bus.data}, 32'hFF);
        chk("par_ready", {31'd0, bus.ready}, 32'd0);
`else
        send_frame(8'h1D, 1'b1, 1'b1, 1'b1);
        $display("bad parity (ignored): data=%0h ready=%0b", bus.data, bus.ready);
        chk("par_data", {24'd0, bus.data}, 32'h1D);
        chk("par_ready", {31'd0, bus.ready}, 32'd1);
`endif

        // Let outstanding echoes drain, bounded
        wait_cnt = 0;
        while (echo_q.size() > 0 && wait_cnt < 1000) begin
            @(negedge clk);
            wait_cnt++;
        end
        repeat (250) @(negedge clk);
        chk("echo_drain", echo_q.size(), 32'd0);
        chk("final_tx_idle", {31'd0, bus.tx_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
